// File: rtl/pool2d_stream.sv
// Streaming KxK (stride K) max/average pooling behind the conv engine; keeps one row of partial windows.
// Optional fused ReLU on the pooled value when POOL_RELU_EN is defined.
module pool2d_stream #(
    parameter int DATA_W = 16,
    parameter int K      = 2,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    localparam int OW     = IMG_W / K,
    localparam int OH     = IMG_H / K,
    localparam int IDX_W  = $clog2(K * K),
    localparam int ADDR_W = (OW * OH > 1) ? $clog2(OW * OH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     done
);

    localparam int LK    = $clog2(K);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int SW    = (OW > 1) ? $clog2(OW) : 1;
    localparam int SUM_W = DATA_W + IDX_W;
    localparam int NOUT  = OW * OH;

    // Window mean: arithmetic shift floors toward -inf, then truncate to pixel width.
    function automatic logic signed [DATA_W-1:0] f_avg(input logic signed [SUM_W-1:0] s);
        return DATA_W'(s >>> IDX_W);
    endfunction

    function automatic logic signed [DATA_W-1:0] f_relu(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? '0 : v;
    endfunction

    logic [CW-1:0]              r_col;
    logic [RW-1:0]              r_row;
    logic                       r_mode;
    logic [ADDR_W-1:0]          r_addr_cnt;
    logic signed [DATA_W-1:0]   r_max [OW];
    logic [IDX_W-1:0]           r_idx [OW];
    logic signed [SUM_W-1:0]    r_sum [OW];

    logic                       r_vld_p1;
    logic signed [DATA_W-1:0]   r_data_p1;
    logic [IDX_W-1:0]           r_idx_p1;
    logic [ADDR_W-1:0]          r_addr_p1;
    logic                       r_last_p1;

    logic                       w_in_ready;
    logic                       w_accept;
    logic [IDX_W-1:0]           w_pos;
    logic [SW-1:0]              w_slot;
    logic                       w_first_pos;
    logic                       w_last_pos;
    logic                       w_col_end;
    logic                       w_row_end;
    logic                       w_frame_first;
    logic                       w_mode;
    logic                       w_gt;
    logic signed [SUM_W-1:0]    w_ext;
    logic signed [SUM_W-1:0]    w_fsum;
    logic signed [DATA_W-1:0]   w_fmax;
    logic [IDX_W-1:0]           w_fidx;
    logic signed [DATA_W-1:0]   w_pooled;
    logic signed [DATA_W-1:0]   w_result;

    assign w_in_ready    = !(r_vld_p1 && !out_ready);
    assign w_accept      = in_valid && w_in_ready;
    assign w_pos         = {r_row[LK-1:0], r_col[LK-1:0]};
    assign w_slot        = SW'(r_col >> LK);
    assign w_first_pos   = (w_pos == '0);
    assign w_last_pos    = &w_pos;
    assign w_col_end     = (r_col == CW'(IMG_W - 1));
    assign w_row_end     = (r_row == RW'(IMG_H - 1));
    assign w_frame_first = (r_row == '0) && (r_col == '0);
    assign w_mode        = w_frame_first ? mode : r_mode;

    assign w_gt   = in_data > r_max[w_slot];
    assign w_ext  = {{IDX_W{in_data[DATA_W-1]}}, in_data};
    assign w_fsum = r_sum[w_slot] + w_ext;
    assign w_fmax = w_gt ? in_data : r_max[w_slot];
    assign w_fidx = w_gt ? w_pos : r_idx[w_slot];

    assign w_pooled = w_mode ? f_avg(w_fsum) : w_fmax;
`ifdef POOL_RELU_EN
    assign w_result = f_relu(w_pooled);
`else
    assign w_result = w_pooled;
`endif

    // Stage p0: per-slot partial window state, overwritten on each window's first pixel.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (w_first_pos) begin
                r_max[w_slot] <= in_data;
                r_idx[w_slot] <= '0;
                r_sum[w_slot] <= w_ext;
            end else begin
                r_max[w_slot] <= w_fmax;
                r_idx[w_slot] <= w_fidx;
                r_sum[w_slot] <= w_fsum;
            end
        end
    end

    // Stage p1: raster counters, frame mode latch and the registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col      <= '0;
            r_row      <= '0;
            r_mode     <= 1'b0;
            r_addr_cnt <= '0;
            r_vld_p1   <= 1'b0;
            r_data_p1  <= '0;
            r_idx_p1   <= '0;
            r_addr_p1  <= '0;
            r_last_p1  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_col <= w_col_end ? '0 : r_col + 1'b1;
                if (w_col_end) begin
                    r_row <= w_row_end ? '0 : r_row + 1'b1;
                end
                if (w_frame_first) begin
                    r_mode <= mode;
                end
            end
            // Windows complete in output raster order, so a running count gives the address.
            if (w_accept && w_last_pos) begin
                r_vld_p1   <= 1'b1;
                r_data_p1  <= w_result;
                r_idx_p1   <= w_mode ? '0 : w_fidx;
                r_addr_p1  <= r_addr_cnt;
                r_last_p1  <= (r_addr_cnt == ADDR_W'(NOUT - 1));
                r_addr_cnt <= (r_addr_cnt == ADDR_W'(NOUT - 1)) ? '0 : r_addr_cnt + 1'b1;
            end else if (out_ready) begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_vld_p1;
    assign out_data  = r_data_p1;
    assign out_idx   = r_idx_p1;
    assign out_addr  = r_addr_p1;
    assign done      = r_vld_p1 && out_ready && r_last_p1;

endmodule
